// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
//
// Purpose:
//   Drives four LEDs with a selectable pattern. The pattern only runs after
//   the PLL lock indicator has been seen high continuously for a
//   qualification period. Pattern steps are paced by a dwell counter.
//
//   Mode changes are deferred until the next dwell tick. On that tick the
//   LEDs load the new mode's initial pattern.
//
//   Losing lock always wins over a pattern update: the block falls back to
//   WAIT_LOCK and blanks the LEDs.
//
// Ports:
//   Clk        in   1  single clock (PLL output domain), rising edge
//   Rst_n      in   1  asynchronous active-low reset
//   Locked     in   1  PLL lock indicator, asynchronous to Clk
//   Mode       in   2  00 off, 01 chase-left, 10 chase-right, 11 blink-all
//   LED        out  4  registered LED drive, 1 = on
//   Ready      out  1  registered, high only while in RUN
//   fsm_state  out  2  current FSM state (0 WAIT_LOCK, 1 STABLE, 2 RUN)
//
// Parameters:
//   CNT_MAX    last dwell count; one pattern step lasts CNT_MAX+1 cycles
//   LOCK_CNT   extra consecutive locked cycles required in STABLE
// -----------------------------------------------------------------------------
module led_seq_ctrl #(
   parameter int CNT_MAX  = 24_999_999,
   parameter int LOCK_CNT = 1023
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Locked,
   input  logic [1:0] Mode,
   output logic [3:0] LED,
   output logic       Ready,
   output logic [1:0] fsm_state
);

   localparam int DW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int LW = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(CNT_MAX);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CNT);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic           lk_m, lk_s;
   logic [LW-1:0]  lock_cnt, lock_cnt_nxt;
   logic [DW-1:0]  dwell, dwell_nxt;
   logic [3:0]     led_q, led_nxt;
   logic           ready_q, ready_nxt;
   logic [1:0]     applied, applied_nxt;
   logic           tick;
   logic           lock_done;

   function automatic logic [3:0] init_pattern(input logic [1:0] m);
      case (m)
         2'b01:   return 4'b0001;
         2'b10:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // Two-flop synchroniser for the asynchronous lock indicator.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         lk_m <= 1'b0;
         lk_s <= 1'b0;
      end else begin
         lk_m <= Locked;
         lk_s <= lk_m;
      end
   end

   assign tick      = (dwell == DWELL_LAST);
   assign lock_done = (lock_cnt == LOCK_LAST);

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= WAIT_LOCK;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOCK: if (lk_s) state_nxt = STABLE;
         STABLE: begin
            if (!lk_s)          state_nxt = WAIT_LOCK;
            else if (lock_done) state_nxt = RUN;
         end
         RUN:       if (!lk_s) state_nxt = WAIT_LOCK;
         default:   state_nxt = WAIT_LOCK;
      endcase
   end

   // Output / datapath next values; everything below is registered.
   always_comb begin
      lock_cnt_nxt = '0;
      dwell_nxt    = '0;
      led_nxt      = 4'b0000;
      ready_nxt    = 1'b0;
      applied_nxt  = applied;
      case (state)
         WAIT_LOCK: begin
            // All outputs and counters held at zero.
         end
         STABLE: begin
            if (lk_s) begin
               if (lock_done) begin
                  // Edge entering RUN: start the pattern of the current Mode.
                  ready_nxt   = 1'b1;
                  led_nxt     = init_pattern(Mode);
                  applied_nxt = Mode;
               end else begin
                  lock_cnt_nxt = lock_cnt + LW'(1);
               end
            end
         end
         RUN: begin
            // A lost lock blanks the LEDs even if this cycle is a tick.
            if (lk_s) begin
               ready_nxt = 1'b1;
               led_nxt   = led_q;
               dwell_nxt = tick ? '0 : dwell + DW'(1);
               if (tick) begin
                  if (Mode != applied) begin
                     // A mode change restarts the pattern; no step this tick.
                     led_nxt     = init_pattern(Mode);
                     applied_nxt = Mode;
                  end else begin
                     case (applied)
                        2'b01:   led_nxt = {led_q[2:0], led_q[3]};
                        2'b10:   led_nxt = {led_q[0], led_q[3:1]};
                        2'b11:   led_nxt = ~led_q;
                        default: led_nxt = 4'b0000;
                     endcase
                  end
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         lock_cnt <= '0;
         dwell    <= '0;
         led_q    <= 4'b0000;
         ready_q  <= 1'b0;
         applied  <= 2'b00;
      end else begin
         lock_cnt <= lock_cnt_nxt;
         dwell    <= dwell_nxt;
         led_q    <= led_nxt;
         ready_q  <= ready_nxt;
         applied  <= applied_nxt;
      end
   end

   assign LED       = led_q;
   assign Ready     = ready_q;
   assign fsm_state = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
//
// Purpose:
//   Self-checking bench for led_seq_ctrl with CNT_MAX=24 and LOCK_CNT=15.
//
// Reference model:
//   - The bench keeps the history of Locked.
//   - The synchronised lock seen at edge n is the Locked value driven for
//     edge n-2.
//   - Ready is high after an edge once the run of consecutive seen-high edges
//     reaches LOCK_CNT+2.
//   - The LED value is a function of the applied mode and the number of
//     steps taken in that mode.
//
// Ports:
//   none
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

   localparam int CNT_MAX  = 24;
   localparam int LOCK_CNT = 15;
   localparam int DWELL    = CNT_MAX + 1;
   localparam int QUAL     = LOCK_CNT + 2;

   logic       Clk;
   logic       Rst_n;
   logic       Locked;
   logic [1:0] Mode;
   logic [3:0] LED;
   logic       Ready;
   logic [1:0] fsm_state;

   led_seq_ctrl #(.CNT_MAX(CNT_MAX), .LOCK_CNT(LOCK_CNT)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Locked    (Locked),
      .Mode      (Mode),
      .LED       (LED),
      .Ready     (Ready),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset block ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit         hist[$];
   int         run_len = 0;   // consecutive edges with synchronised lock high
   int         t_run   = 0;   // cycles since entering RUN
   int         steps   = 0;   // pattern steps taken in the applied mode
   logic [1:0] am      = 2'b00;

   function automatic logic [3:0] pat(input logic [1:0] m, input int j);
      logic [3:0] one_l;
      logic [3:0] one_r;
      one_l = 4'b0001;
      one_r = 4'b1000;
      case (m)
         2'b01:   return one_l << (j % 4);
         2'b10:   return one_r >> (j % 4);
         2'b11:   return (j % 2) ? 4'hF : 4'h0;
         default: return 4'h0;
      endcase
   endfunction

   task automatic model_reset();
      hist.delete();
      run_len = 0;
      t_run   = 0;
      steps   = 0;
      am      = 2'b00;
   endtask

   task automatic model_edge(input bit lk, input logic [1:0] md);
      bit seen;
      hist.push_back(lk);
      seen    = (hist.size() >= 3) ? hist[hist.size() - 3] : 1'b0;
      run_len = seen ? run_len + 1 : 0;
      if (run_len == QUAL) begin
         am    = md;
         steps = 0;
         t_run = 0;
      end else if (run_len > QUAL) begin
         t_run++;
         if (t_run % DWELL == 0) begin
            if (md == am) steps++;
            else begin
               am    = md;
               steps = 0;
            end
         end
      end
      if (run_len >= QUAL) exp_q.push_back({1'b1, pat(am, steps)});
      else                 exp_q.push_back(5'b0_0000);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input bit lk, input logic [1:0] md, input string tag);
      logic [4:0] exp;
      Locked = lk;
      Mode   = md;
      @(posedge Clk);
      model_edge(lk, md);
      @(negedge Clk);
      exp = exp_q.pop_front();
      check(tag, {27'd0, Ready, LED}, {27'd0, exp});
   endtask

   task automatic drive_n(input int n, input bit lk, input logic [1:0] md, input string tag);
      for (int i = 0; i < n; i++) drive_cycle(lk, md, tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         rise;
      logic [3:0] led_at_rise;
      int         guard;
      int         drop_left;
      logic [1:0] md;
      bit         lk;

      Rst_n  = 1'b0;
      Locked = 1'b1;
      Mode   = 2'b01;
      model_reset();
      repeat (3) @(negedge Clk);
      check("reset_led", {28'd0, LED}, 32'd0);
      check("reset_ready", {31'd0, Ready}, 32'd0);
      Rst_n = 1'b1;

      // Qualification latency with Locked constantly high.
      rise        = 0;
      led_at_rise = 4'hx;
      for (int i = 1; i <= 40; i++) begin
         drive_cycle(1'b1, 2'b01, "qual");
         if (Ready && rise == 0) begin
            rise        = i;
            led_at_rise = LED;
         end
      end
      check("ready_latency", rise, 2 + 1 + LOCK_CNT + 1);
      check("led_at_ready", {28'd0, led_at_rise}, 32'd1);

      // Chase left, then a switch to blink mid-dwell, then chase right.
      drive_n(110, 1'b1, 2'b01, "chase_left");
      drive_n(12, 1'b1, 2'b01, "pre_switch");
      drive_n(90, 1'b1, 2'b11, "blink");
      drive_n(110, 1'b1, 2'b10, "chase_right");

      // Lock drop whose synchronised edge lands exactly on a tick.
      guard = 0;
      while (guard < 100 && !(run_len >= QUAL && ((t_run + 3) % DWELL) == 0)) begin
         drive_cycle(1'b1, 2'b01, "seek_tick");
         guard++;
      end
      check("tick_found", {31'd0, guard < 100}, 32'd1);
      drive_n(6, 1'b0, 2'b01, "drop_on_tick");
      drive_n(30, 1'b1, 2'b01, "relock");

      // Single-cycle lock glitch while STABLE at count 10.
      drive_n(8, 1'b0, 2'b10, "unlock");
      guard = 0;
      while (guard < 50 && run_len != 9) begin
         drive_cycle(1'b1, 2'b10, "stable_fill");
         guard++;
      end
      check("stable_reach", {31'd0, guard < 50}, 32'd1);
      drive_cycle(1'b0, 2'b10, "stable_glitch");
      drive_n(60, 1'b1, 2'b10, "requal");

      // Randomised modes and lock drops.
      md        = 2'b01;
      drop_left = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
         if (drop_left == 0 && $urandom_range(0, 299) == 0) drop_left = $urandom_range(1, 30);
         lk = (drop_left == 0);
         if (drop_left > 0) drop_left--;
         drive_cycle(lk, md, "random");
      end

      // Asynchronous reset between clock edges while running.
      guard = 0;
      while (guard < 200 && run_len < QUAL + 30) begin
         drive_cycle(1'b1, 2'b11, "run_before_rst");
         guard++;
      end
      check("run_before_rst_reached", {31'd0, guard < 200}, 32'd1);
      Locked = 1'b1;
      Mode   = 2'b01;
      drive_n(40, 1'b1, 2'b01, "run_before_rst");
      check("ready_before_rst", {31'd0, Ready}, 32'd1);
      @(posedge Clk);
      #3;
      Rst_n = 1'b0;
      #1;
      check("async_rst_led", {28'd0, LED}, 32'd0);
      check("async_rst_ready", {31'd0, Ready}, 32'd0);
      model_reset();
      @(negedge Clk);
      @(negedge Clk);
      check("rst_hold_led", {28'd0, LED}, 32'd0);
      Rst_n = 1'b1;
      drive_n(70, 1'b1, 2'b10, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
